// File: rtl/bundle_packer.sv
// bundle_packer: packs program-ordered 16-bit instructions into 32-bit {slot2, slot1} bundles.
//   clk, rst      : clock; synchronous active-high reset
//   in_valid/in_ready/in_instr : instruction input handshake (opcode = in_instr[4:0])
//   flush         : force out any held slot1 op
//   bundle_valid/bundle_ready/bundle : registered bundle output handshake
//   err_illegal   : one-cycle pulse after an illegal opcode is accepted
//   bundle_cnt, nop_cnt : wrapping counts of emitted bundles and NOP halves emitted
module bundle_packer #(
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_instr,
    input  logic             flush,
    output logic             bundle_valid,
    input  logic             bundle_ready,
    output logic [31:0]      bundle,
    output logic             err_illegal,
    output logic [CNT_W-1:0] bundle_cnt,
    output logic [CNT_W-1:0] nop_cnt
);
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;
    // Wide enough to reach TIMEOUT and still saturate one step above it.
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] TO_V = TW'(TIMEOUT);

    logic [0:0]       state_q, state_d;
    logic [15:0]      held_q, held_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             bv_q, bv_d;
    logic [31:0]      bundle_q, bundle_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] ncnt_q, ncnt_d;

    logic [4:0]  op;
    logic        is_alu, is_mem, is_nop, is_ill;
    logic        hold, out_free, flush_emit, timeout_emit, force_emit, accept, handshake;
    logic        emit;
    logic [31:0] emit_word;

    assign op     = in_instr[4:0];
    assign is_alu = op inside {5'b01000, 5'b00101};
    assign is_mem = op inside {5'b01010, 5'b01011, 5'b11110, 5'b11011};
    assign is_nop = op == 5'b00000;
    assign is_ill = !(is_alu || is_mem || is_nop);

    assign hold         = state_q == S_HOLD;
    assign out_free     = !bv_q || bundle_ready;
    assign flush_emit   = flush && hold && out_free;
    assign timeout_emit = (TIMEOUT != 0) && hold && (timer_q >= TO_V) && out_free;
    // Flush and timeout share one emit path, so a coincidence yields a single bundle.
    assign force_emit   = flush_emit || timeout_emit;
    assign in_ready     = out_free && !force_emit;
    assign accept       = in_valid && in_ready;
    assign handshake    = bv_q && bundle_ready;

    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        emit      = 1'b0;
        emit_word = 32'h0;
        if (force_emit) begin
            emit      = 1'b1;
            emit_word = {16'h0, held_q};
            state_d   = S_EMPTY;
        end else if (accept && !hold) begin
            held_d    = is_alu ? in_instr : held_q;
            state_d   = is_alu ? S_HOLD : S_EMPTY;
            emit      = is_mem;
            emit_word = {in_instr, 16'h0};
        end else if (accept) begin
            // A held ALU op only pairs with a following MEM op; anything else pushes it out alone.
            emit      = 1'b1;
            emit_word = is_mem ? {in_instr, held_q} : {16'h0, held_q};
            held_d    = is_alu ? in_instr : held_q;
            state_d   = is_alu ? S_HOLD : S_EMPTY;
        end
    end

    assign timer_d  = (accept || !hold || force_emit) ? '0 :
                      (timer_q == '1) ? timer_q : timer_q + 1'b1;
    assign bv_d     = emit || (bv_q && !bundle_ready);
    assign bundle_d = emit ? emit_word : bundle_q;
    assign err_d    = accept && is_ill;
    assign bcnt_d   = handshake ? bcnt_q + 1'b1 : bcnt_q;
    assign ncnt_d   = handshake ? ncnt_q + CNT_W'(bundle_q[15:0] == 16'h0)
                                         + CNT_W'(bundle_q[31:16] == 16'h0) : ncnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_EMPTY;
            held_q   <= 16'h0;
            timer_q  <= '0;
            bv_q     <= 1'b0;
            bundle_q <= 32'h0;
            err_q    <= 1'b0;
            bcnt_q   <= '0;
            ncnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            timer_q  <= timer_d;
            bv_q     <= bv_d;
            bundle_q <= bundle_d;
            err_q    <= err_d;
            bcnt_q   <= bcnt_d;
            ncnt_q   <= ncnt_d;
        end
    end

    assign bundle_valid = bv_q;
    assign bundle       = bundle_q;
    assign err_illegal  = err_q;
    assign bundle_cnt   = bcnt_q;
    assign nop_cnt      = ncnt_q;
endmodule
